// File: rtl/eq_pkg.sv
// Shared equalizer definitions: band count, gain code width, bus packing and ramp FSM states.
package eq_pkg;

    localparam int unsigned EQ_BANDS = 8;
    localparam int unsigned EQ_GW    = 5;
    localparam int unsigned EQ_BUS_W = EQ_BANDS * EQ_GW;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } eq_state_e;

    // Band k occupies bits [k*EQ_GW +: EQ_GW] of the packed gain bus.
    function automatic int unsigned band_lsb(input int unsigned band);
        return band * EQ_GW;
    endfunction

endpackage

// File: rtl/eq_band_stepper.sv
// Per-band live gain register: moves one code toward its target on i_step, or jumps to it on i_load.
module eq_band_stepper
    import eq_pkg::*;
#(
    parameter int unsigned GW = EQ_GW
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_step,
    input  logic          i_load,
    input  logic [GW-1:0] i_target,
    output logic [GW-1:0] o_live
);

    logic [GW-1:0] r_live;

    // Unit step cannot overshoot, so codes stay inside 0..2^GW-1 without clamping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= '0;
        end else if (i_load) begin
            r_live <= i_target;
        end else if (i_step) begin
            if (r_live < i_target) begin
                r_live <= r_live + GW'(1);
            end else if (r_live > i_target) begin
                r_live <= r_live - GW'(1);
            end
        end
    end

    assign o_live = r_live;

endmodule

// File: rtl/eq_gain_ramp.sv
// Gain control for Digital_Equalizer: holds per-band targets and walks live codes toward them on sample ticks.
// GAIN_RAMP_EN defined: one-code step every RAMP_DIV ticks; undefined: targets load on the first tick in RAMP.
module eq_gain_ramp
    import eq_pkg::*;
#(
    parameter int unsigned BANDS    = EQ_BANDS,
    parameter int unsigned GW       = EQ_GW,
    parameter int unsigned RAMP_DIV = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            wr_band,
    input  logic [GW-1:0]         wr_gain,
    input  logic                  preset_valid,
    input  logic [BANDS*GW-1:0]   preset_gain,
    output logic [BANDS*GW-1:0]   gain_out,
    output logic                  ramping,
    output logic                  settled
);

    if ((RAMP_DIV < 1) || (BANDS != EQ_BANDS) || (GW != EQ_GW)) begin : g_bad_cfg
        $error("eq_gain_ramp: unsupported BANDS/GW/RAMP_DIV configuration");
    end

    logic [GW-1:0]    r_target [BANDS];
    logic [GW-1:0]    w_live   [BANDS];
    logic [BANDS-1:0] w_diff;
    logic             w_any_diff;
    logic             w_wr_fire;
    logic             w_step;
    logic             w_load;
    eq_state_e        r_state;

    // A preset stalls a concurrent single-band write for one cycle rather than dropping it.
    assign wr_ready  = rst_n & ~preset_valid;
    assign w_wr_fire = wr_valid & wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < BANDS; k++) begin
                r_target[k] <= '0;
            end
        end else if (preset_valid) begin
            for (int unsigned k = 0; k < BANDS; k++) begin
                r_target[k] <= preset_gain[band_lsb(k) +: GW];
            end
        end else if (w_wr_fire) begin
            r_target[wr_band] <= wr_gain;
        end
    end

    for (genvar k = 0; k < BANDS; k++) begin : g_band
        eq_band_stepper #(.GW(GW)) u_stepper (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_step   (w_step),
            .i_load   (w_load),
            .i_target (r_target[k]),
            .o_live   (w_live[k])
        );
        assign w_diff[k] = (w_live[k] != r_target[k]);
        assign gain_out[band_lsb(k) +: GW] = w_live[k];
    end

    assign w_any_diff = |w_diff;

`ifdef GAIN_RAMP_EN
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    logic [DIV_W-1:0] r_div;

    assign w_step = (r_state == RAMP) && sample_tick && (r_div == DIV_LAST);
    assign w_load = 1'b0;
`else
    assign w_step = 1'b0;
    assign w_load = (r_state == RAMP) && sample_tick;
`endif

    // Ramp FSM; ramping mirrors the state and settled lags the live/target compare by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            ramping <= 1'b0;
            settled <= 1'b1;
`ifdef GAIN_RAMP_EN
            r_div   <= '0;
`endif
        end else begin
            settled <= ~w_any_diff;
            case (r_state)
                IDLE: begin
`ifdef GAIN_RAMP_EN
                    r_div <= '0;
`endif
                    if (w_any_diff) begin
                        r_state <= RAMP;
                        ramping <= 1'b1;
                    end
                end
                RAMP: begin
                    if (!w_any_diff) begin
                        r_state <= IDLE;
                        ramping <= 1'b0;
`ifdef GAIN_RAMP_EN
                        r_div   <= '0;
`endif
                    end
`ifdef GAIN_RAMP_EN
                    else if (sample_tick) begin
                        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    ramping <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/eq_gain_ramp.md
Name: eq_gain_ramp

Overview:
- Upstream control stage for Digital_Equalizer; generates its 40-bit `gain` bus (8 bands x 5-bit code, band k at bits [5k+4:5k]).
- Accepts per-band writes or a full 8-band preset and moves each band's live gain one code step at a time, paced by the audio sample strobe, so gain changes never cause zipper noise.
- Live gain changes only on sample boundaries, so the equalizer always sees a stable gain for a whole sample.

Parameters:
- BANDS, 8, number of equalizer bands
- GW, 5, bits per band gain code (unsigned, 0..31)
- RAMP_DIV, 16, sample ticks per one-code ramp step (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle strobe, once per audio sample (16 kHz)
- wr_valid  in  1  single-band write request
- wr_ready  out  1  single-band write accepted when wr_valid&&wr_ready
- wr_band  in  3  band index 0..7
- wr_gain  in  GW  target code for wr_band
- preset_valid  in  1  load all 8 targets this cycle (always accepted)
- preset_gain  in  BANDS*GW  packed targets, same layout as gain_out
- gain_out  out  BANDS*GW  live gain bus to Digital_Equalizer `gain`
- ramping  out  1  FSM in RAMP
- settled  out  1  all live codes equal their targets

Behaviour:
- Reset (async, rst_n=0): all targets=0, all live codes=0, gain_out=0, divider=0, FSM=IDLE, ramping=0, settled=1. wr_ready=0 while rst_n=0.
- wr_ready = !preset_valid (combinational). A preset and a write in the same cycle: the preset wins and the write is stalled, not dropped.
- Target update: registered on the accept cycle. The preset overwrites all 8 targets. A write to the same band twice: last write wins.
- FSM IDLE:
  - Divider held at 0.
  - On the cycle after any target differs from its live code, go to RAMP.
  - A write equal to the current live code causes no transition.
- FSM RAMP:
  - The divider counts sample_ticks 0..RAMP_DIV-1.
  - On a sample_tick with divider==RAMP_DIV-1, every band with live!=target steps by exactly 1 toward its target (increment or decrement). The divider then wraps to 0.
  - Steps never overshoot and never wrap, since codes are clamped to 0..31 by construction.
- Retarget mid-ramp: the new target takes effect at the next step. The divider is not restarted. A band reversing direction steps from its current live code.
- Leaving RAMP: on the cycle after all live==target, return to IDLE and clear the divider.
- settled is registered: it is 1 exactly when all live==target, updated one cycle after any change.
- Latency from write accept to first gain_out change = RAMP_DIV sample_ticks (the first step lands on the RAMP_DIV-th tick after entering RAMP). A full-scale 0->31 swing takes 31*RAMP_DIV ticks.
- gain_out is registered. It changes only in the cycle after a step tick and is constant between steps.
- sample_tick in IDLE is ignored.
- Reset mid-ramp: immediate return to all-zero gain and settled=1.

Optional Feature:
- Macro GAIN_RAMP_EN.
- Defined: ramped behaviour as above.
- Undefined: the divider is removed. On the first sample_tick in RAMP, all live codes load their targets directly, then the block returns to IDLE. Updates stay sample-aligned, but with no ramp.
- Ports and reset values are identical in both builds.

Decomposition:
- Shared package eq_pkg:
  - constants EQ_BANDS=8, EQ_GW=5
  - gain-bus packing helper (band index -> bit offset)
  - FSM state typedef {IDLE, RAMP}
  - eq_pkg is also used by Digital_Equalizer for bus layout.
- One natural sub-module, eq_band_stepper: per-band live register with a step toward target, instantiated 8 times. The FSM and divider stay in the top.

Test Plan:
- Reset: rst_n low mid-ramp -> gain_out=0, settled=1, ramping=0, wr_ready=0 immediately. After release, wr_ready=1.
- Single write: band 0 <- 3, RAMP_DIV=16 -> ramping=1 next cycle; band0 reads 1, 2, 3 after the 16th, 32nd and 48th sample_tick; settled=1 one cycle after the 48th tick's update; no other bits change.
- Preset down-ramp: live all 5, preset all 2 -> all bands decrement together on each 16th tick, reaching 2 after 48 ticks, then IDLE.
- Collision: preset_valid and wr_valid (band 1 <- 7) in the same cycle -> wr_ready=0 that cycle and the preset is applied. The write is accepted the next cycle, and band 1's final value is 7.
- Retarget: band 2 ramping 0->10 at live=4, write 1 -> next step gives 3, then 2, then 1; the divider phase is unchanged.
- No-op and build variant: write band 0 <- 0 at reset state -> no RAMP, ramping stays 0. With GAIN_RAMP_EN undefined, write band 0 <- 31 -> gain_out band0=31 on the first sample_tick after the write.
